// File: rtl/arm_hazard_scoreboard.sv
// arm_hazard_scoreboard: ID hazard/forwarding unit; in id_* operands, out hazard stall, fwd_sel_rn/rm (0=regfile, k=entry k-1), stall_cnt
module arm_hazard_scoreboard #(
  parameter int REG_W  = 4,
  parameter int DEPTH  = 3,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         freeze,
  input  logic                         flush,
  input  logic                         id_valid,
  input  logic [REG_W-1:0]             id_rn,
  input  logic [REG_W-1:0]             id_rm,
  input  logic                         id_uses_rn,
  input  logic                         id_two_src,
  input  logic                         id_wb_en,
  input  logic                         id_mem_r_en,
  input  logic [REG_W-1:0]             id_dest,
  output logic                         hazard,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_sel_rn,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_sel_rm,
  output logic [CNT_W-1:0]             stall_cnt
);
  localparam int SW = $clog2(DEPTH+1);
  logic [DEPTH-1:0] v, w, m, mn, mm;
  logic [REG_W-1:0] d [DEPTH];
  logic [SW-1:0]    sn, sm;
  logic             rn_req, rm_req, raw;
  assign rn_req = id_valid & id_uses_rn;
  assign rm_req = id_valid & id_two_src;
  always_comb begin
    mn = '0;
    mm = '0;
    sn = '0;
    sm = '0;
    for (int k = 0; k < DEPTH; k++) begin
      mn[k] = v[k] & w[k] & (d[k] == id_rn);
      mm[k] = v[k] & w[k] & (d[k] == id_rm);
    end
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (mn[k]) sn = SW'(k + 1);
      if (mm[k]) sm = SW'(k + 1);
    end
  end
  assign raw = (FWD_EN != 0) ? m[0] & ((rn_req & mn[0]) | (rm_req & mm[0]))
                             : (rn_req & |mn) | (rm_req & |mm);
  assign hazard     = rst & raw & ~flush & ~freeze;
  assign fwd_sel_rn = ((FWD_EN != 0) && rst && rn_req) ? sn : '0;
  assign fwd_sel_rm = ((FWD_EN != 0) && rst && rm_req) ? sm : '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v         <= '0;
      w         <= '0;
      m         <= '0;
      stall_cnt <= '0;
      for (int k = 0; k < DEPTH; k++) d[k] <= '0;
    end else if (!freeze) begin
      for (int k = 1; k < DEPTH; k++) begin
        v[k] <= v[k-1];
        w[k] <= w[k-1];
        m[k] <= m[k-1];
        d[k] <= d[k-1];
      end
      v[0] <= id_valid & ~flush & ~hazard;
      w[0] <= id_wb_en;
      m[0] <= id_mem_r_en;
      d[0] <= id_dest;
      if (hazard && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_arm_hazard_scoreboard.sv
// tb_arm_hazard_scoreboard: directed checks of forwarding (FWD_EN=1) and stall-only (FWD_EN=0) instances
module tb_arm_hazard_scoreboard;
  logic       clk = 0, rst = 0, freeze = 0, flush = 0;
  logic       id_valid = 0, id_uses_rn = 0, id_two_src = 0, id_wb_en = 0, id_mem_r_en = 0;
  logic [3:0] id_rn = 0, id_rm = 0, id_dest = 0;
  logic       h1, h0;
  logic [1:0] rn1, rm1, rn0, rm0;
  logic [15:0] c1, c0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  arm_hazard_scoreboard #(.REG_W(4), .DEPTH(3), .FWD_EN(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_valid(id_valid),
    .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_two_src(id_two_src),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .hazard(h1), .fwd_sel_rn(rn1), .fwd_sel_rm(rm1), .stall_cnt(c1));

  arm_hazard_scoreboard #(.REG_W(4), .DEPTH(3), .FWD_EN(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_valid(id_valid),
    .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_two_src(id_two_src),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .hazard(h0), .fwd_sel_rn(rn0), .fwd_sel_rm(rm0), .stall_cnt(c0));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic urn, input logic [3:0] rn, input logic two,
                     input logic [3:0] rm, input logic wb, input logic mr, input logic [3:0] dst);
    id_valid = v; id_uses_rn = urn; id_rn = rn; id_two_src = two; id_rm = rm;
    id_wb_en = wb; id_mem_r_en = mr; id_dest = dst;
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_h1"}, h1, 0);
    chk({tag, "_rn1"}, rn1, 0);
    chk({tag, "_rm1"}, rm1, 0);
    chk({tag, "_c1"}, c1, 0);
    chk({tag, "_h0"}, h0, 0);
    chk({tag, "_rn0"}, rn0, 0);
    chk({tag, "_rm0"}, rm0, 0);
    chk({tag, "_c0"}, c0, 0);
  endtask

  task automatic rst_pulse(input string tag);
    rst = 0;
    #1;
    all_zero(tag);
    rst = 1;
    #1;
  endtask

  initial begin
    // reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      freeze = 1'($urandom); flush = 1'($urandom);
      drv(1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
          1'($urandom), 1'($urandom), 4'($urandom));
      all_zero("in_reset");
      cyc();
    end
    freeze = 0; flush = 0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      drv(0, 1, 4'd1, 1, 4'd1, 1, 1, 4'd1);
      all_zero("invalid");
      cyc();
    end
    // forwarding pipeline: ADD r1 then consumer of r1
    drv(1, 0, 0, 0, 0, 1, 0, 4'd1);
    chk("add_h", h1, 0);
    cyc();
    drv(1, 1, 4'd1, 0, 0, 0, 0, 4'd9);
    chk("fwd1_h", h1, 0); chk("fwd1_sel", rn1, 1);
    cyc();
    chk("fwd2_h", h1, 0); chk("fwd2_sel", rn1, 2);
    cyc();
    chk("fwd3_h", h1, 0); chk("fwd3_sel", rn1, 3);
    cyc();
    chk("fwd4_h", h1, 0); chk("fwd4_sel", rn1, 0);
    rst_pulse("rstA");
    // load-use
    drv(1, 0, 0, 0, 0, 1, 1, 4'd2);
    cyc();
    drv(1, 1, 4'd2, 0, 0, 0, 0, 4'd9);
    chk("lu_h", h1, 1); chk("lu_c0", c1, 0);
    cyc();
    chk("lu_h2", h1, 0); chk("lu_sel", rn1, 2); chk("lu_c1", c1, 1);
    cyc();
    chk("lu_c_after", c1, 1);
    rst_pulse("rstB");
    // priority and two sources: r3 in entries 0 and 2, r7 in entry 1
    drv(1, 0, 0, 0, 0, 1, 0, 4'd3);
    cyc();
    drv(1, 0, 0, 0, 0, 1, 0, 4'd7);
    cyc();
    drv(1, 0, 0, 0, 0, 1, 0, 4'd3);
    cyc();
    drv(1, 1, 4'd5, 1, 4'd3, 0, 0, 4'd9);
    chk("pri_h", h1, 0); chk("pri_rm", rm1, 1); chk("pri_rn", rn1, 0);
    drv(1, 1, 4'd5, 0, 4'd3, 0, 0, 4'd9);
    chk("one_src_rm", rm1, 0); chk("one_src_rn", rn1, 0);
    drv(1, 1, 4'd3, 1, 4'd7, 0, 0, 4'd9);
    chk("mid_rm", rm1, 2); chk("mid_rn", rn1, 1);
    rst_pulse("rstC");
    // stall-only instance: writer r4 then consumer of r4
    drv(1, 0, 0, 0, 0, 1, 0, 4'd4);
    cyc();
    drv(1, 1, 4'd4, 0, 0, 0, 0, 4'd9);
    chk("so1_h", h0, 1); chk("so1_sel", rn0, 0); chk("so1_c", c0, 0);
    chk("so1_fwd_inst", rn1, 1);
    cyc();
    chk("so2_h", h0, 1); chk("so2_sel", rn0, 0); chk("so2_c", c0, 1);
    cyc();
    chk("so3_h", h0, 1); chk("so3_sel", rn0, 0); chk("so3_c", c0, 2);
    cyc();
    chk("so4_h", h0, 0); chk("so4_sel", rn0, 0); chk("so4_c", c0, 3);
    cyc();
    chk("so5_h", h0, 0); chk("so5_c", c0, 3);
    rst_pulse("rstD");
    // flush kills a load that would otherwise create a load-use hazard
    drv(1, 0, 0, 0, 0, 1, 1, 4'd2);
    cyc();
    flush = 1;
    drv(1, 1, 4'd2, 0, 0, 1, 1, 4'd2);
    chk("fl_h", h1, 0);
    cyc();
    flush = 0;
    #1;
    chk("fl_bubble_h", h1, 0); chk("fl_bubble_sel", rn1, 2); chk("fl_c", c1, 0);
    cyc();
    drv(1, 1, 4'd2, 0, 0, 0, 0, 4'd9);
    chk("pre_frz_h", h1, 1);
    freeze = 1;
    #1;
    chk("frz_h", h1, 0); chk("frz_sel", rn1, 1); chk("frz_c", c1, 0);
    cyc();
    chk("frz1_sel", rn1, 1); chk("frz1_c", c1, 0);
    cyc();
    chk("frz2_sel", rn1, 1); chk("frz2_c", c1, 0);
    freeze = 0;
    #1;
    chk("unfrz_h", h1, 1);
    cyc();
    chk("unfrz_h2", h1, 0); chk("unfrz_sel", rn1, 2); chk("unfrz_c", c1, 1);
    // asynchronous reset mid-sequence
    rst = 0;
    #1;
    chk("mid_rst_h", h1, 0); chk("mid_rst_rn", rn1, 0); chk("mid_rst_rm", rm1, 0);
    chk("mid_rst_c", c1, 0);
    rst = 1;
    #1;
    chk("post_rst_sel", rn1, 0); chk("post_rst_h", h1, 0);
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
